// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller (master) and the data memory (slave).
// Single-beat req/ack: req is held until a one-cycle ack pulse returns read data.
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs a req/ack data-memory access, stalls upstream while it is
// outstanding, and produces the registered MEM/WB writeback signals.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              inWrtIndex,
  input  logic                    inRegWrEn,
  input  logic [1:0]              inMulSel,
  input  logic [31:0]             inAluOut,
  input  logic [31:0]             inData2Out,
  input  logic [31:0]             inPC,
  input  logic                    inIsLoad,
  input  logic                    inIsStore,
  output logic                    memStall,
  mem_stage_ctrl_if.master        dmem,
  output logic [3:0]              wbWrtIndex,
  output logic                    wbRegWrEn,
  output logic [31:0]             wbData,
  output logic                    memErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] wb_select(input logic [1:0] sel, input logic [31:0] alu,
                                            input logic [31:0] ld, input logic [31:0] pc);
    case (sel)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return pc;
      default: return 32'h0;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_aborted, w_aborted_nxt;
  logic [31:0]      r_ld_data, w_ld_data_nxt;
  logic             r_req, w_req_nxt;
  logic             r_we, w_we_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic [3:0]       r_wb_idx, w_wb_idx_nxt;
  logic             r_wb_en, w_wb_en_nxt;
  logic [31:0]      r_wb_data, w_wb_data_nxt;
  logic             r_err, w_err_nxt;
  logic             w_access;
  logic [31:0]      w_wb_sel;

  assign w_access = inIsLoad | inIsStore;
  assign w_wb_sel = wb_select(inMulSel, inAluOut, r_ld_data, inPC);
  assign memStall = ((r_state == S_IDLE) && w_access) || (r_state == S_BUSY);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_aborted_nxt = r_aborted;
    w_ld_data_nxt = r_ld_data;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wb_idx_nxt  = r_wb_idx;
    w_wb_en_nxt   = r_wb_en;
    w_wb_data_nxt = r_wb_data;
    w_err_nxt     = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          // A load takes priority when both request bits are set.
          w_state_nxt   = S_BUSY;
          w_req_nxt     = 1'b1;
          w_we_nxt      = ~inIsLoad;
          w_addr_nxt    = {inAluOut[31:2], 2'b00};
          w_wdata_nxt   = inData2Out;
          w_wb_en_nxt   = 1'b0;
          w_aborted_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_wb_idx_nxt  = inWrtIndex;
          w_wb_en_nxt   = inRegWrEn;
          w_wb_data_nxt = w_wb_sel;
        end
      end
      S_BUSY: begin
        w_wb_en_nxt = 1'b0;
        if (dmem.dmem_ack) begin
          w_ld_data_nxt = dmem.dmem_rdata;
          w_req_nxt     = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DONE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_req_nxt     = 1'b0;
          w_err_nxt     = 1'b1;
          w_aborted_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      S_DONE: begin
        // Stall is released here, so the held instruction retires on this edge.
        w_wb_idx_nxt  = inWrtIndex;
        w_wb_en_nxt   = r_aborted ? 1'b0 : inRegWrEn;
        w_wb_data_nxt = w_wb_sel;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
      r_req     <= RESET_VALUE[0];
      r_we      <= RESET_VALUE[0];
      r_addr    <= RESET_VALUE;
      r_wdata   <= RESET_VALUE;
      r_wb_idx  <= RESET_VALUE[3:0];
      r_wb_en   <= RESET_VALUE[0];
      r_wb_data <= RESET_VALUE;
      r_err     <= RESET_VALUE[0];
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_aborted <= w_aborted_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wb_idx  <= w_wb_idx_nxt;
      r_wb_en   <= w_wb_en_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_ld_data <= w_ld_data_nxt;
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign wbWrtIndex      = r_wb_idx;
  assign wbRegWrEn       = r_wb_en;
  assign wbData          = r_wb_data;
  assign memErr          = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: an instruction-level model predicts each retirement
// (writeback, stall length, error flag) and a memory responder checks the bus side.
module tb_mem_stage_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  inWrtIndex;
  logic        inRegWrEn;
  logic [1:0]  inMulSel;
  logic [31:0] inAluOut, inData2Out, inPC;
  logic        inIsLoad, inIsStore;
  logic        memStall;
  logic [3:0]  wbWrtIndex;
  logic        wbRegWrEn;
  logic [31:0] wbData;
  logic        memErr;

  mem_stage_ctrl_if bus();

  mem_stage_ctrl #(.TIMEOUT(T), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .reset(reset),
    .inWrtIndex(inWrtIndex), .inRegWrEn(inRegWrEn), .inMulSel(inMulSel),
    .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
    .inIsLoad(inIsLoad), .inIsStore(inIsStore),
    .memStall(memStall), .dmem(bus),
    .wbWrtIndex(wbWrtIndex), .wbRegWrEn(wbRegWrEn), .wbData(wbData), .memErr(memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic        en;
    logic [31:0] data;
    logic        chk_data;
    int          stall;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] m_ld = 32'h0;
  logic        m_ld_known = 1'b0;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a low stall sample means the instruction retires at the next posedge.
  initial begin
    logic have_prev;
    logic prev_stall;
    int   stall_run;
    exp_t e;
    have_prev = 1'b0;
    prev_stall = 1'b0;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (have_prev && !prev_stall) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", 32'h1, 32'h0);
          end else begin
            e = q.pop_front();
            chk("wb_idx", 32'(wbWrtIndex), 32'(e.idx));
            chk("wb_en", 32'(wbRegWrEn), 32'(e.en));
            if (e.chk_data) chk("wb_data", wbData, e.data);
            chk("stall_cycles", 32'(stall_run), 32'(e.stall));
            chk("mem_err", 32'(memErr), 32'(e.err));
          end
          stall_run = 0;
        end
        if (memStall) stall_run++;
        prev_stall = memStall;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
        stall_run = 0;
      end
    end
  end

  task automatic wait_retire();
    int   n;
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      s = memStall;
      @(posedge clk);
      n++;
    end while (s && n < 64);
    if (s) chk("retire_timeout", 32'h1, 32'h0);
    #1;
  endtask

  task automatic respond(input int k, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rd);
    int w;
    int cnt;
    w = 0;
    @(negedge clk);
    while (bus.dmem_req !== 1'b1 && w < 4) begin
      w++;
      @(negedge clk);
    end
    if (bus.dmem_req !== 1'b1) begin
      chk("req_rise_timeout", 32'h1, 32'h0);
      return;
    end
    chk("bus_addr", bus.dmem_addr, addr);
    chk("bus_we", 32'(bus.dmem_we), 32'(we));
    chk("bus_wdata", bus.dmem_wdata, wdata);
    if (k >= 1 && k <= T) begin
      for (int i = 1; i < k; i++) begin
        @(negedge clk);
        chk("req_hold", 32'(bus.dmem_req), 32'h1);
      end
      chk("addr_hold", bus.dmem_addr, addr);
      bus.dmem_ack = 1'b1;
      bus.dmem_rdata = rd;
      @(posedge clk);
      #1;
      bus.dmem_ack = 1'b0;
      chk("req_drop_ack", 32'(bus.dmem_req), 32'h0);
    end else begin
      cnt = 0;
      while (bus.dmem_req === 1'b1 && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      chk("busy_cycles_timeout", 32'(cnt), 32'(T));
      if (k > T) begin
        // Late ack after the abort must not disturb anything.
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = rd;
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
      end
    end
  endtask

  task automatic stray_ack(input logic [31:0] rd);
    @(negedge clk);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = rd;
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] d2,
                       input logic [31:0] pc, input logic [3:0] idx, input logic en,
                       input logic ld, input logic st, input int k, input logic stray,
                       input logic [31:0] rd);
    exp_t e;
    logic acc;
    logic acked;
    acc = ld | st;
    acked = acc && (k >= 1) && (k <= T);
    if (acked) begin
      m_ld = rd;
      m_ld_known = 1'b1;
    end
    if (acc && !acked) m_err = 1'b1;
    e.idx = idx;
    e.en = (acc && !acked) ? 1'b0 : en;
    case (sel)
      2'd0: e.data = alu;
      2'd1: e.data = m_ld;
      2'd2: e.data = pc;
      default: e.data = 32'h0;
    endcase
    e.chk_data = !(sel == 2'd1 && !m_ld_known);
    e.stall = !acc ? 0 : (acked ? 1 + k : 1 + T);
    e.err = m_err;
    q.push_back(e);
    inMulSel = sel; inAluOut = alu; inData2Out = d2; inPC = pc;
    inWrtIndex = idx; inRegWrEn = en; inIsLoad = ld; inIsStore = st;
    fork
      begin
        if (acc) respond(k, {alu[31:2], 2'b00}, !ld, d2, rd);
        else if (stray) stray_ack(rd);
      end
      wait_retire();
    join
  endtask

  initial begin
    logic [1:0]  r_op;
    logic        ld, st;
    int          k;
    reset = 1'b1;
    inWrtIndex = '0; inRegWrEn = 1'b0; inMulSel = '0; inAluOut = '0;
    inData2Out = '0; inPC = '0; inIsLoad = 1'b0; inIsStore = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_we", 32'(bus.dmem_we), 32'h0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_wb_idx", 32'(wbWrtIndex), 32'h0);
    chk("rst_wb_en", 32'(wbRegWrEn), 32'h0);
    chk("rst_wb_data", wbData, 32'h0);
    chk("rst_err", 32'(memErr), 32'h0);
    chk("rst_stall", 32'(memStall), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    issue(2'd0, 32'h1234, 32'h0, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    issue(2'd1, 32'h103, 32'h0, 32'h0, 4'd3, 1'b1, 1'b1, 1'b0, 2, 1'b0, 32'hDEADBEEF);
    issue(2'd0, 32'h40, 32'hCAFE0001, 32'h0, 4'd7, 1'b0, 1'b0, 1'b1, 1, 1'b0, 32'h0BAD0BAD);
    issue(2'd1, 32'h88, 32'h11112222, 32'h0, 4'd2, 1'b1, 1'b1, 1'b1, T, 1'b0, 32'h600DF00D);
    issue(2'd2, 32'h0, 32'h0, 32'h10000004, 4'd14, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'hFFFFFFFF);
    issue(2'd3, 32'h77, 32'h0, 32'h55, 4'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    issue(2'd1, 32'h300, 32'h0, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h12345678);
    issue(2'd0, 32'h55, 32'h0, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);

    for (int n = 0; n < 250; n++) begin
      r_op = 2'($urandom_range(0, 2));
      ld = (r_op == 2'd1);
      st = (r_op == 2'd2) || (ld && ($urandom % 6 == 0));
      k = ($urandom % 5 == 0) ? $urandom_range(0, T + 2) : $urandom_range(1, T);
      issue(2'($urandom), $urandom, $urandom, $urandom, 4'($urandom), ($urandom % 4 != 0),
            ld, st, k, ($urandom % 4 == 0), $urandom);
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("queue_empty", 32'(q.size()), 32'h0);

    // Reset while a load is outstanding, then a stale ack.
    @(posedge clk);
    #1;
    inIsLoad = 1'b1; inIsStore = 1'b0; inAluOut = 32'h200; inRegWrEn = 1'b1; inMulSel = 2'd1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_req_before_rst", 32'(bus.dmem_req), 32'h1);
    reset = 1'b1;
    inIsLoad = 1'b0; inRegWrEn = 1'b0; inMulSel = 2'd0;
    @(posedge clk);
    #1;
    chk("rst_busy_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_busy_stall", 32'(memStall), 32'h0);
    chk("rst_clears_err", 32'(memErr), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_stall", 32'(memStall), 32'h0);
      chk("late_ack_req", 32'(bus.dmem_req), 32'h0);
      chk("late_ack_wb_en", 32'(wbRegWrEn), 32'h0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
